// File: rtl/run_sequencer.sv
// Replays a CPU-loaded instruction program into experiment_fsm for a programmed
// number of rounds, handling run_trig/halt handshaking, timeout and abort.
module run_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int INSTR_W      = 17,
  parameter int TRIG_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_wr_en,
  input  logic [ADDR_W-1:0]  prog_wr_addr,
  input  logic [INSTR_W-1:0] prog_wr_data,
  input  logic [ADDR_W:0]    prog_len,
  input  logic [15:0]        num_rounds,
  input  logic               start,
  input  logic               abort,
  output logic               run_trig,
  output logic               halt,
  output logic [INSTR_W-1:0] instr_tdata,
  output logic               instr_tvalid,
  input  logic               instr_tready,
  input  logic               run_done,
  input  logic               fsm_err,
  output logic               busy,
  output logic               seq_done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [15:0]        round_count,
  output logic [2:0]         state_out
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_TRIG      = 3'd1;
  localparam logic [2:0] S_STREAM    = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RELEASE   = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] S_ERR       = 3'd6;

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam int              TW      = $clog2(TRIG_TIMEOUT + 1);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [TW-1:0]   CNT_ONE = 1;
  localparam logic [TW-1:0]   CNT_LAST = TW'(TRIG_TIMEOUT - 1);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] rd_data_q;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [15:0]       rounds_q, rounds_d;
  logic [15:0]       round_count_q, round_count_d;
  logic              seq_done_q, seq_done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              run_trig_q, halt_q, tvalid_q, busy_q;

  logic at_rest, running, fsm_watch, handshake, last_word, bad_cfg;

  assign at_rest   = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
  assign running   = (state_q == S_TRIG) || (state_q == S_STREAM) ||
                     (state_q == S_WAIT_DONE) || (state_q == S_RELEASE);
  assign fsm_watch = (state_q == S_TRIG) || (state_q == S_STREAM) || (state_q == S_WAIT_DONE);
  assign handshake = tvalid_q && instr_tready;
  assign last_word = ({1'b0, ptr_q} == (len_q - LEN_ONE));
  assign bad_cfg   = (prog_len == '0) || (prog_len > MAX_LEN) || (num_rounds == '0);

  always_ff @(posedge clk) begin
    if (prog_wr_en && at_rest) begin
      mem[prog_wr_addr] <= prog_wr_data;
    end
  end

  // Always read the word that will be presented next, so data is ready the
  // cycle STREAM begins and stays put while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[ptr_d];
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    rounds_d      = rounds_q;
    round_count_d = round_count_q;
    seq_done_d    = seq_done_q;
    err_d         = err_q;
    err_code_d    = err_code_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          seq_done_d    = 1'b0;
          err_d         = 1'b0;
          err_code_d    = 2'd0;
          round_count_d = '0;
          if (bad_cfg) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end else begin
            len_d    = prog_len;
            rounds_d = num_rounds;
            ptr_d    = '0;
            cnt_d    = '0;
            state_d  = S_TRIG;
          end
        end
      end
      S_TRIG: begin
        if (!run_done) begin
          state_d = S_STREAM;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = S_ERR;
          err_d      = 1'b1;
          err_code_d = 2'd2;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STREAM: begin
        if (handshake) begin
          if (last_word) begin
            state_d = S_WAIT_DONE;
          end else begin
            ptr_d = ptr_q + PTR_ONE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (run_done) begin
          state_d       = S_RELEASE;
          round_count_d = round_count_q + 16'd1;
          cnt_d         = '0;
        end
      end
      S_RELEASE: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_ONE;
        end else if (round_count_q == rounds_q) begin
          state_d    = S_DONE;
          seq_done_d = 1'b1;
        end else begin
          state_d = S_TRIG;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Faults override whatever the normal path decided, including a round
    // that would otherwise have been counted this cycle.
    if ((abort && running) || (fsm_err && fsm_watch)) begin
      state_d       = S_ERR;
      err_d         = 1'b1;
      err_code_d    = 2'd3;
      round_count_d = round_count_q;
      seq_done_d    = seq_done_q;
      ptr_d         = ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
      rounds_q      <= '0;
      round_count_q <= '0;
      seq_done_q    <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 2'd0;
      run_trig_q    <= 1'b0;
      halt_q        <= 1'b1;
      tvalid_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      rounds_q      <= rounds_d;
      round_count_q <= round_count_d;
      seq_done_q    <= seq_done_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      run_trig_q    <= (state_d == S_TRIG) || (state_d == S_STREAM) || (state_d == S_WAIT_DONE);
      halt_q        <= !((state_d == S_TRIG) || (state_d == S_STREAM));
      tvalid_q      <= (state_d == S_STREAM);
      busy_q        <= !((state_d == S_IDLE) || (state_d == S_DONE));
    end
  end

  assign run_trig     = run_trig_q;
  assign halt         = halt_q;
  assign instr_tdata  = rd_data_q;
  assign instr_tvalid = tvalid_q;
  assign busy         = busy_q;
  assign seq_done     = seq_done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign round_count  = round_count_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: a behavioural FSM responder plus a
// program-replay reference model, table-driven runs and hand-written fault cases.
module tb_run_sequencer;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 17;
  localparam int DEPTH   = 1 << ADDR_W;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               prog_wr_en = 1'b0;
  logic [ADDR_W-1:0]  prog_wr_addr = '0;
  logic [INSTR_W-1:0] prog_wr_data = '0;
  logic [ADDR_W:0]    prog_len = '0;
  logic [15:0]        num_rounds = '0;
  logic               start = 1'b0, abort = 1'b0;
  logic               run_trig, halt, instr_tvalid, busy, seq_done, err;
  logic [INSTR_W-1:0] instr_tdata;
  logic               instr_tready = 1'b1;
  logic               run_done = 1'b0;
  logic               fsm_err = 1'b0;
  logic [1:0]         err_code;
  logic [15:0]        round_count;
  logic [2:0]         state_out;

  run_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .TRIG_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .prog_wr_en(prog_wr_en), .prog_wr_addr(prog_wr_addr),
    .prog_wr_data(prog_wr_data), .prog_len(prog_len), .num_rounds(num_rounds),
    .start(start), .abort(abort), .run_trig(run_trig), .halt(halt),
    .instr_tdata(instr_tdata), .instr_tvalid(instr_tvalid), .instr_tready(instr_tready),
    .run_done(run_done), .fsm_err(fsm_err), .busy(busy), .seq_done(seq_done),
    .err(err), .err_code(err_code), .round_count(round_count), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int rounds;
    int mode;       // 0 always ready, 1 pattern 1,0,0, 2 random
    int exp_code;
    int exp_rounds;
    int exp_done;
    int exp_pulses;
  } vec_t;

  int n_tests = 0, n_fail = 0;
  logic [INSTR_W-1:0] prog_mem [DEPTH];
  logic [INSTR_W-1:0] got_q [$];
  int ready_mode = 0, cyc = 0, dly = 0;
  bit stuck_done = 0;
  int trig_pulses, low_run, gap_bad, stall_bad;
  logic prev_trig = 1'b0, prev_stall = 1'b0;
  logic [INSTR_W-1:0] prev_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic upd_ready();
    case (ready_mode)
      0: instr_tready = 1'b1;
      1: instr_tready = ((cyc % 3) == 0);
      default: instr_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One clock: log the handshake at this edge, advance, then let the FSM model respond.
  task automatic step();
    logic want;
    if (instr_tvalid && instr_tready) got_q.push_back(instr_tdata);
    prev_stall = instr_tvalid && !instr_tready;
    prev_data  = instr_tdata;
    @(posedge clk);
    #1;
    cyc++;
    if (run_trig) begin
      if (!prev_trig) begin
        trig_pulses++;
        if (trig_pulses > 1 && low_run != 2) gap_bad++;
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_trig = run_trig;
    if (prev_stall && (!instr_tvalid || instr_tdata !== prev_data)) stall_bad++;
    if (stuck_done) begin
      run_done = 1'b1;
    end else begin
      want = run_done;
      if (run_trig && !halt) want = 1'b0;
      else if (run_trig && halt) want = 1'b1;
      if (want != run_done) begin
        if (dly == 0) begin
          run_done = want;
          dly = $urandom_range(0, 3);
        end else begin
          dly--;
        end
      end
    end
    upd_ready();
  endtask

  task automatic begin_run(input int len, input int rounds, input int mode);
    got_q.delete();
    trig_pulses = 0; gap_bad = 0; stall_bad = 0; low_run = 0;
    ready_mode = mode;
    upd_ready();
    prog_len = (ADDR_W + 1)'(len);
    num_rounds = 16'(rounds);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int budget, bad_words;
    begin_run(v.len, v.rounds, v.mode);
    check({tag, ".trig_at_1"}, run_trig, (v.exp_code == 0));
    budget = 0;
    while (state_out != 3'd5 && state_out != 3'd6 && budget < 5000) begin
      // Junk writes while running must be ignored by the sequencer.
      prog_wr_en   = (state_out >= 3'd1 && state_out <= 3'd4);
      prog_wr_addr = ADDR_W'($urandom);
      prog_wr_data = INSTR_W'($urandom);
      step();
      budget++;
    end
    prog_wr_en = 1'b0;
    check({tag, ".finished"}, (budget < 5000), 1);
    check({tag, ".err_code"}, err_code, v.exp_code);
    check({tag, ".err"}, err, (v.exp_code != 0));
    check({tag, ".seq_done"}, seq_done, v.exp_done);
    check({tag, ".round_count"}, round_count, v.exp_rounds);
    check({tag, ".busy"}, busy, (v.exp_code != 0));
    check({tag, ".idle_outs"}, {run_trig, halt, instr_tvalid}, 3'b010);
    check({tag, ".trig_pulses"}, trig_pulses, v.exp_pulses);
    check({tag, ".handshakes"}, got_q.size(), (v.exp_code == 0) ? v.len * v.rounds : 0);
    bad_words = 0;
    foreach (got_q[i]) if (got_q[i] !== prog_mem[i % v.len]) bad_words++;
    check({tag, ".stream_data"}, bad_words, 0);
    check({tag, ".trig_gap"}, gap_bad, 0);
    check({tag, ".stall_stable"}, stall_bad, 0);
  endtask

  task automatic fault_case(input int kind, input string tag);
    int budget;
    logic [43:0] rv;
    begin_run(4, 5, 0);
    budget = 0;
    while (!(round_count == 16'd2 && instr_tvalid && got_q.size() == 10) && budget < 2000) begin
      step();
      budget++;
    end
    check({tag, ".reached"}, (budget < 2000), 1);
    check({tag, ".word2"}, instr_tdata, prog_mem[2]);
    if (kind == 2) begin
      rst = 1'b0;
      #2;
      rv = '0; rv[42] = 1'b1;
      check({tag, ".async_reset"}, {run_trig, halt, instr_tvalid, instr_tdata, busy, seq_done,
                                    err, err_code, round_count, state_out}, rv);
      step();
      check({tag, ".held_reset"}, {busy, state_out, halt}, 5'b00001);
      rst = 1'b1;
      step();
    end else begin
      if (kind == 0) fsm_err = 1'b1; else abort = 1'b1;
      step();
      fsm_err = 1'b0; abort = 1'b0;
      check({tag, ".state"}, state_out, 3'd6);
      check({tag, ".err_code"}, err_code, 2'd3);
      check({tag, ".round_count"}, round_count, 16'd2);
      check({tag, ".outs"}, {run_trig, halt, instr_tvalid, err}, 4'b0101);
    end
  endtask

  initial begin
    vec_t tbl [8];
    vec_t rv;
    logic [43:0] rst_vec;
    int n;
    tbl[0] = '{3,   1, 0, 0, 1, 1, 1};
    tbl[1] = '{4,   1, 1, 0, 1, 1, 1};
    tbl[2] = '{2,   5, 2, 0, 5, 1, 5};
    tbl[3] = '{0,   1, 0, 1, 0, 0, 0};
    tbl[4] = '{257, 1, 0, 1, 0, 0, 0};
    tbl[5] = '{2,   0, 0, 1, 0, 0, 0};
    tbl[6] = '{256, 2, 2, 0, 2, 1, 2};
    tbl[7] = '{1,   3, 2, 0, 3, 1, 3};

    repeat (3) @(posedge clk);
    #1;
    rst_vec = '0; rst_vec[42] = 1'b1;
    check("reset_state", {run_trig, halt, instr_tvalid, instr_tdata, busy, seq_done,
                          err, err_code, round_count, state_out}, rst_vec);
    rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      prog_mem[i]  = (i == 0) ? 17'h00001 : (i == 1) ? 17'h00006 : (i == 2) ? 17'h00080
                                                                  : INSTR_W'($urandom);
      prog_wr_en   = 1'b1;
      prog_wr_addr = ADDR_W'(i);
      prog_wr_data = prog_mem[i];
      step();
    end
    prog_wr_en = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 4; i++) begin
      rv.len = $urandom_range(1, 20);
      rv.rounds = $urandom_range(1, 4);
      rv.mode = 2;
      rv.exp_code = 0; rv.exp_rounds = rv.rounds; rv.exp_done = 1; rv.exp_pulses = rv.rounds;
      run_vec(rv, $sformatf("rand%0d", i));
    end

    // Timeout: run_done never falls after run_trig.
    stuck_done = 1'b1;
    run_done = 1'b1;
    begin_run(2, 1, 0);
    n = 0;
    while (state_out == 3'd1 && n < 40) begin
      step();
      n++;
    end
    check("timeout.cycles", n, 16);
    check("timeout.state", state_out, 3'd6);
    check("timeout.err_code", err_code, 2'd2);
    check("timeout.outs", {run_trig, halt, instr_tvalid, err}, 4'b0101);
    stuck_done = 1'b0;
    repeat (2) step();

    fault_case(0, "fsm_err");
    fault_case(1, "abort");
    fault_case(2, "reset");

    rv = '{3, 2, 2, 0, 2, 1, 2};
    run_vec(rv, "recover");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/run_sequencer.md
# run_sequencer

Multi-round program sequencer placed in front of `experiment_fsm`. The CPU loads an instruction program into local program RAM, then issues a single start. The block then replays that program into the FSM's instruction stream for `num_rounds` consecutive runs. For each round it drives `run_trig`/`halt`, waits for `run_done`, releases the trigger, and aborts cleanly on FSM error or CPU abort.

## Interface
- `ADDR_W`, 8: program RAM address width; depth is 2^ADDR_W words.
- `INSTR_W`, 17: instruction word width; matches the FSM `instr_axis_tdata` width.
- `TRIG_TIMEOUT`, 16: maximum number of cycles to wait for `run_done` to fall after `run_trig` is raised.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `prog_wr_en`  in  1  program RAM write strobe from the CPU.
- `prog_wr_addr`  in  ADDR_W  write address.
- `prog_wr_data`  in  INSTR_W  write data.
- `prog_len`  in  ADDR_W+1  number of words per round; valid range 1..2^ADDR_W.
- `num_rounds`  in  16  number of rounds to run; valid range 1..65535.
- `start`  in  1  single-cycle pulse that starts a sequence.
- `abort`  in  1  single-cycle pulse that stops the sequence.
- `run_trig`  out  1  to the FSM `run_trig`.
- `halt`  out  1  to the FSM `halt`.
- `instr_tdata`  out  INSTR_W  instruction word to the FSM.
- `instr_tvalid`  out  1  instruction stream valid.
- `instr_tready`  in  1  instruction stream ready, from the FSM.
- `run_done`  in  1  from the FSM.
- `fsm_err`  in  1  from the FSM `err_out`.
- `busy`  out  1  high in every state except IDLE and DONE.
- `seq_done`  out  1  sticky; set on entering DONE.
- `err`  out  1  sticky; set on any error or abort.
- `err_code`  out  2  error cause: 0 none, 1 bad config, 2 trigger timeout, 3 FSM error or abort.
- `round_count`  out  16  number of rounds completed.
- `state_out`  out  3  current state encoding.

## Operation
- **States:** IDLE=0, TRIG=1, STREAM=2, WAIT_DONE=3, RELEASE=4, DONE=5, ERR=6.
- **Reset values:** all outputs 0, except `halt`=1. State is IDLE. Program RAM contents are not reset.
- **Program writes:** accepted only in IDLE, DONE or ERR. Writes in any other state are dropped.
- **IDLE / DONE / ERR, on `start`:**
  - Clear `seq_done`, `err`, `err_code` and `round_count`.
  - If `prog_len`=0, `prog_len`>2^ADDR_W or `num_rounds`=0: set `err`=1, `err_code`=1, go to ERR.
  - Otherwise latch `prog_len` and `num_rounds` and go to TRIG.
- **`start` in other states:** ignored.
- **TRIG:**
  - `run_trig`=1, `halt`=0, `instr_tvalid`=0. Read of word 0 is issued.
  - When `run_done`=0 is sampled, go to STREAM.
  - If `run_done` has not fallen after TRIG_TIMEOUT cycles, go to ERR with `err_code`=2.
- **STREAM:**
  - `instr_tdata` holds word `ptr`, with `instr_tvalid`=1.
  - On `instr_tvalid & instr_tready`, `ptr` increments. Throughput is 1 word per cycle under continuous ready.
  - `instr_tdata` is stable while `instr_tvalid & !instr_tready`.
  - After the handshake of word `prog_len`-1: `instr_tvalid`=0, `halt`=1, go to WAIT_DONE.
- **WAIT_DONE:** when `run_done`=1 is sampled, go to RELEASE.
- **RELEASE:**
  - `run_trig`=0 for exactly 2 cycles, so the FSM leaves wait_rst.
  - `round_count` increments on entry.
  - If `round_count` equals `num_rounds`, go to DONE and set `seq_done`. Otherwise reset `ptr` to 0 and go to TRIG.
- **Errors:**
  - `fsm_err`=1 in TRIG, STREAM or WAIT_DONE, or `abort` in any busy state, goes to ERR with `err_code`=3.
  - On entering ERR: `run_trig`=0, `halt`=1, `instr_tvalid`=0.
  - The partially completed round is not counted.
- **Simultaneous events:** `abort` takes priority over `fsm_err`, which takes priority over a normal transition. If `abort` and a final handshake land in the same cycle, the result is ERR.
- **Mid-operation reset:** all outputs return to their reset values immediately; `halt`=1 keeps the FSM stoppable.

## Timing
- `start` at cycle 0 → `run_trig`=1 at cycle 1.
- `run_done` sampled low at cycle n → STREAM at n+1, with word 0 `instr_tvalid`=1 at n+1.
- The last handshake at cycle m → `halt`=1 and `instr_tvalid`=0 at m+1.
- `run_done`=1 sampled at cycle p → `run_trig`=0 at p+1 and p+2 → `run_trig`=1 again at p+3 for the next round, or DONE at p+3.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Load and single round:** load 3 words (0x00001, 0x00006, 0x00080) with `prog_len`=3 and `num_rounds`=1, FSM model always ready → exactly 3 handshakes in order, then `halt`=1, `seq_done`=1, `round_count`=1, `err`=0.
- **Backpressure:** `prog_len`=4, `instr_tready` toggling 1,0,0,1,… → `instr_tdata` stable while stalled, no words lost or duplicated, 4 handshakes total.
- **Multi-round:** `num_rounds`=5, `prog_len`=2 → 5 `run_trig` pulses, each with a low gap of 2 cycles; 10 handshakes; final `round_count`=5.
- **Bad configuration:** `prog_len`=0, then `prog_len`=2^ADDR_W+1, then `num_rounds`=0 → `err_code`=1 each time, `run_trig` never rises.
- **Timeout:** FSM model holds `run_done`=1 → ERR after 16 cycles, `err_code`=2, `run_trig`=0, `halt`=1.
- **Fault during stream:** `fsm_err` pulse during word 2 of round 3 → ERR, `err_code`=3, `round_count`=2. Repeat with `abort`; repeat with a reset asserted mid-STREAM → all outputs at reset values.
